// File: rtl/reconfigurable_inverse_filter.sv
// Deconvolving receiver for the reconfigurable FIR/IIR filter: rebuilds x[n] from y[n]
// with a single time-shared multiplier stepped through an 8-state sequence per sample.
module reconfigurable_inverse_filter #(
    parameter int WIDTH  = 8,
    parameter int B0     = 3,
    parameter int B0_INV = 171,
    parameter int B1     = 1,
    parameter int B2     = 3,
    parameter int B3     = 4,
    parameter int A1     = 2,
    parameter int A2     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             control,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready
);

    // An even B0 has no inverse modulo 2^WIDTH, so reconstruction would be impossible.
    if ((B0 % 2) == 0) begin : g_b0_check
        $error("reconfigurable_inverse_filter: B0 must be odd");
    end

    localparam logic [WIDTH-1:0] C_B0_INV = WIDTH'(B0_INV);
    localparam logic [WIDTH-1:0] C_B1     = WIDTH'(B1);
    localparam logic [WIDTH-1:0] C_B2     = WIDTH'(B2);
    localparam logic [WIDTH-1:0] C_B3     = WIDTH'(B3);
    localparam logic [WIDTH-1:0] C_A1     = WIDTH'(A1);
    localparam logic [WIDTH-1:0] C_A2     = WIDTH'(A2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC1,
        S_MAC2,
        S_MAC3,
        S_MAC4,
        S_MAC5,
        S_SCALE,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_fir;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y_in;
    logic [WIDTH-1:0] r_x1;
    logic [WIDTH-1:0] r_x2;
    logic [WIDTH-1:0] r_x3;
    logic [WIDTH-1:0] r_y1;
    logic [WIDTH-1:0] r_y2;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic [WIDTH-1:0] w_coef;
    logic [WIDTH-1:0] w_opnd;
    logic [WIDTH-1:0] w_prod;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_MAC1;
            S_MAC1:  w_state_next = S_MAC2;
            S_MAC2:  w_state_next = S_MAC3;
            S_MAC3:  w_state_next = S_MAC4;
            S_MAC4:  w_state_next = S_MAC5;
            S_MAC5:  w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand select for the shared multiplier; SCALE reuses it for the B0_INV product.
    always_comb begin
        w_coef = '0;
        w_opnd = '0;
        case (r_state)
            S_MAC1: begin
                w_coef = r_fir ? '0 : C_A1;
                w_opnd = r_y1;
            end
            S_MAC2: begin
                w_coef = r_fir ? '0 : C_A2;
                w_opnd = r_y2;
            end
            S_MAC3: begin
                w_coef = C_B1;
                w_opnd = r_x1;
            end
            S_MAC4: begin
                w_coef = C_B2;
                w_opnd = r_x2;
            end
            S_MAC5: begin
                w_coef = r_fir ? C_B3 : '0;
                w_opnd = r_x3;
            end
            S_SCALE: begin
                w_coef = C_B0_INV;
                w_opnd = r_acc;
            end
            default: ;
        endcase
    end

    assign w_prod = w_coef * w_opnd;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fir       <= 1'b0;
            r_acc       <= '0;
            r_y_in      <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc  <= data_in;
                        r_y_in <= data_in;
                        r_fir  <= control;
                    end
                end
                S_MAC1: r_acc <= r_acc + w_prod;
                S_MAC2, S_MAC3, S_MAC4, S_MAC5: r_acc <= r_acc - w_prod;
                S_SCALE: begin
                    r_data_out  <= w_prod;
                    r_x3        <= r_x2;
                    r_x2        <= r_x1;
                    r_x1        <= w_prod;
                    r_y2        <= r_y1;
                    r_y1        <= r_y_in;
                    r_out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_reconfigurable_inverse_filter.sv
// Directed and loopback checks for reconfigurable_inverse_filter at default parameters.
module tb_reconfigurable_inverse_filter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       control = 1'b1;
    logic [7:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    reconfigurable_inverse_filter dut (
        .clock     (clock),
        .reset     (reset),
        .control   (control),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Leaves time at posedge+1 with reset released.
    task automatic pulse_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Drives one sample through; lat = -1 if never accepted, lat >= 40 if no output.
    task automatic send(input logic [7:0] y, input logic mode, input int stall,
                        output logic [7:0] got, output int lat, output logic rdy_after);
        int n = 0;
        got = '0;
        rdy_after = 1'b0;
        lat = -1;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1 n++;
        end
        if (!in_ready) return;
        data_in  = y;
        control  = mode;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        control  = ~mode;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1 lat++;
        end
        if (!out_valid) return;
        repeat (stall) @(posedge clock);
        #1;
        got = data_out;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++;
        if (data_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_data_out got %0d want 0", data_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        $display("reset: data_out=%0d out_valid=%b in_ready=%b", data_out, out_valid, in_ready);
    endtask

    task automatic test_fir_single();
        logic [7:0] got;
        int lat;
        logic rdy;
        send(8'd6, 1'b1, 0, got, lat, rdy);
        checks++;
        if (got !== 8'd2) begin
            errors++;
            $display("FAIL fir_single_data got %0d want 2", got);
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL fir_single_latency got %0d want 6", lat);
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL fir_single_in_ready got %b want 1", rdy);
        end
        $display("fir y=6 -> x=%0d lat=%0d in_ready_after=%b", got, lat, rdy);
    endtask

    task automatic test_fir_history();
        logic [7:0] got;
        int lat;
        logic rdy;
        send(8'd17, 1'b1, 2, got, lat, rdy);
        checks++;
        if (got !== 8'd5) begin
            errors++;
            $display("FAIL fir_history_data got %0d want 5", got);
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL fir_history_latency got %0d want 6", lat);
        end
        $display("fir y=17 -> x=%0d lat=%0d", got, lat);
    endtask

    task automatic test_iir_sequence();
        logic [7:0] got;
        int lat;
        logic rdy;
        pulse_reset();
        send(8'd3, 1'b0, 0, got, lat, rdy);
        checks++;
        if (got !== 8'd1 || lat != 6) begin
            errors++;
            $display("FAIL iir_first got %0d lat %0d want 1 lat 6", got, lat);
        end
        $display("iir y=3 -> x=%0d lat=%0d", got, lat);
        send(8'd254, 1'b0, 1, got, lat, rdy);
        checks++;
        if (got !== 8'd1 || lat != 6) begin
            errors++;
            $display("FAIL iir_second got %0d lat %0d want 1 lat 6", got, lat);
        end
        $display("iir y=254 -> x=%0d lat=%0d", got, lat);
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        int extra = 0;
        pulse_reset();
        data_in  = 8'd6;
        control  = 1'b1;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_out_valid_rise got %b want 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (data_out !== 8'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            if (i == 4) begin
                data_in  = 8'd99;
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold bad_cycles %0d want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) extra++;
            @(posedge clock);
            #1;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL bp_no_extra extra_valid_cycles %0d want 0", extra);
        end
        $display("backpressure: bad_hold=%0d extra=%0d", bad, extra);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int lat;
        logic rdy;
        pulse_reset();
        send(8'd6, 1'b1, 0, got, lat, rdy);
        checks++;
        if (got !== 8'd2) begin
            errors++;
            $display("FAIL mid_pre got %0d want 2", got);
        end
        data_in  = 8'd17;
        control  = 1'b1;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset out_valid %b in_ready %b data_out %0d want 0 1 0",
                     out_valid, in_ready, data_out);
        end
        #1 reset = 1'b0;
        send(8'd6, 1'b1, 0, got, lat, rdy);
        checks++;
        if (got !== 8'd2 || lat != 6) begin
            errors++;
            $display("FAIL mid_after got %0d lat %0d want 2 lat 6", got, lat);
        end
        $display("reset mid-MAC then fir y=6 -> x=%0d", got);
    endtask

    task automatic test_loopback();
        logic [7:0] x, y, got;
        logic [7:0] fx1, fx2, fx3, fy1, fy2;
        logic mode;
        int lat;
        logic rdy;
        for (int blk = 0; blk < 4; blk++) begin
            mode = (blk % 2 == 0);
            pulse_reset();
            fx1 = '0; fx2 = '0; fx3 = '0; fy1 = '0; fy2 = '0;
            for (int i = 0; i < 50; i++) begin
                x = 8'($urandom);
                if (mode) y = 8'(3 * x + fx1 + 3 * fx2 + 4 * fx3);
                else      y = 8'(3 * fy2 - 2 * fy1 + 3 * x + fx1 + 3 * fx2);
                fx3 = fx2; fx2 = fx1; fx1 = x;
                fy2 = fy1; fy1 = y;
                send(y, mode, int'($urandom_range(0, 3)), got, lat, rdy);
                checks++;
                if (got !== x || lat != 6) begin
                    errors++;
                    $display("FAIL loopback blk %0d idx %0d got %0d lat %0d want %0d lat 6",
                             blk, i, got, lat, x);
                end
                $display("loopback blk=%0d mode=%b y=%0d x=%0d got=%0d", blk, mode, y, x, got);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fir_single();
        test_fir_history();
        test_iir_sequence();
        test_backpressure();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
